tt_bin_clock_set_ctrl: RTL

Pushbutton front-end and time-set sequencer for the binary clock counter block. Converts three raw buttons (MODE, UP, DOWN) into the counter's `time_set`, `id_switch`, `hour_id`, `minute_id` and `seconds_id` controls. It sequences the user through hour, minute and second setting with debounce, single-step and auto-repeat behaviour. It sits between the chip input pins and the counter, and runs on the same 100 Hz clock.

---
 rtl/tt_bin_clock_set_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tt_bin_clock_set_ctrl.sv
// rtl/tt_bin_clock_set_ctrl.sv - pushbutton front-end and time-set sequencer for the binary clock
module tt_bin_clock_set_ctrl #(
    parameter int DEBOUNCE      = 3,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int TIMEOUT       = 3000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    output logic       time_set,
    output logic       id_switch,
    output logic       hour_id,
    output logic       minute_id,
    output logic       seconds_id,
    output logic [1:0] field_o
);
    localparam int              DW       = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]   DB_MAX   = DW'(DEBOUNCE);
    localparam logic [7:0]      RD_LIM   = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0]      RP_LIM   = 8'(REPEAT_PERIOD - 1);
    localparam logic [11:0]     IDLE_LIM = 12'(TIMEOUT - 1);
    localparam int              BM       = 0;
    localparam int              BU       = 1;
    localparam int              BD       = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];

    state_t        state;
    state_t        state_n;
    logic [11:0]   idle_cnt;
    logic [11:0]   idle_n;
    logic          rep_active;
    logic          rep_active_n;
    logic          rep_up;
    logic          rep_up_n;
    logic          rep_fast;
    logic          rep_fast_n;
    logic [7:0]    rep_cnt;
    logic [7:0]    rep_cnt_n;
    logic          step;
    logic          step_up;

    logic          mode_press;
    logic          up_press;
    logic          down_press;
    logic          any_press;
    logic          both_held;
    logic          timeout_hit;

    assign raw         = {btn_down_i, btn_up_i, btn_mode_i};
    assign press       = deb & ~deb_q;
    assign mode_press  = press[BM];
    assign up_press    = press[BU];
    assign down_press  = press[BD];
    assign any_press   = |press;
    assign both_held   = deb[BU] & deb[BD];
    assign timeout_hit = (state != ST_RUN) && (idle_cnt >= IDLE_LIM);
    assign field_o     = state;

    // Two-flop synchronizers and per-button debounce counters; a level is accepted once it survives DEBOUNCE+1 samples.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next field, idle timer and step/auto-repeat decisions; MODE and timeout always suppress stepping.
    always_comb begin
        state_n      = state;
        idle_n       = idle_cnt;
        step         = 1'b0;
        step_up      = id_switch;
        rep_active_n = rep_active;
        rep_up_n     = rep_up;
        rep_fast_n   = rep_fast;
        rep_cnt_n    = rep_cnt;

        if (mode_press) begin
            case (state)
                ST_RUN:  state_n = ST_HOUR;
                ST_HOUR: state_n = ST_MIN;
                ST_MIN:  state_n = ST_SEC;
                default: state_n = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_n = ST_RUN;
        end

        if (state == ST_RUN || mode_press || timeout_hit || both_held) begin
            rep_active_n = 1'b0;
            rep_fast_n   = 1'b0;
            rep_cnt_n    = '0;
        end else if (up_press || down_press) begin
            step         = 1'b1;
            step_up      = up_press;
            rep_active_n = 1'b1;
            rep_up_n     = up_press;
            rep_fast_n   = 1'b0;
            rep_cnt_n    = '0;
        end else if (rep_active) begin
            if (rep_up ? deb[BU] : deb[BD]) begin
                if (rep_cnt == (rep_fast ? RP_LIM : RD_LIM)) begin
                    step       = 1'b1;
                    step_up    = rep_up;
                    rep_fast_n = 1'b1;
                    rep_cnt_n  = '0;
                end else begin
                    rep_cnt_n = rep_cnt + 8'd1;
                end
            end else begin
                rep_active_n = 1'b0;
                rep_fast_n   = 1'b0;
                rep_cnt_n    = '0;
            end
        end

        if (state_n == ST_RUN || any_press || state_n != state) begin
            idle_n = '0;
        end else if (idle_cnt != 12'hFFF) begin
            idle_n = idle_cnt + 12'd1;
        end
    end

    // State, timers and registered outputs; step pulses go to the field that was active when the step was decided.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_RUN;
            idle_cnt   <= '0;
            rep_active <= 1'b0;
            rep_up     <= 1'b0;
            rep_fast   <= 1'b0;
            rep_cnt    <= '0;
            time_set   <= 1'b0;
            id_switch  <= 1'b0;
            hour_id    <= 1'b0;
            minute_id  <= 1'b0;
            seconds_id <= 1'b0;
        end else begin
            state      <= state_n;
            idle_cnt   <= idle_n;
            rep_active <= rep_active_n;
            rep_up     <= rep_up_n;
            rep_fast   <= rep_fast_n;
            rep_cnt    <= rep_cnt_n;
            time_set   <= (state_n != ST_RUN);
            hour_id    <= step && (state == ST_HOUR);
            minute_id  <= step && (state == ST_MIN);
            seconds_id <= step && (state == ST_SEC);
            if (step) begin
                id_switch <= step_up;
            end
        end
    end
endmodule
